bram_stream_reader: RTL and testbench

Read-side client for the single-port, 1-cycle-latency block RAM used as the filter's line and frame store. On a start command it walks a contiguous address range and emits the words in order on a valid/ready stream. It hides the RAM's registered read latency behind a 2-entry output buffer, so it sustains 1 word/cycle under no backpressure and never loses or duplicates a word under backpressure. It sits between the RAM port and the median-window logic.

---
 rtl/bram_stream_reader_pkg.sv | 13 +
 rtl/bram_stream_reader_stream_fifo2.sv | 54 +++++
 rtl/bram_stream_reader.sv | 103 ++++++++++
 tb/tb_bram_stream_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM burst reader and its output buffer.
package bram_stream_reader_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

endpackage

// File: rtl/bram_stream_reader_stream_fifo2.sv
// Two-entry FIFO that absorbs the RAM's read latency; head entry drives the stream.
module stream_fifo2
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [OCC_W-1:0]  occ_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop_i && (occ_q != '0);
    assign do_push = push_i && ((occ_q != OCC_W'(BUF_DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset so the stream data reads as zero after reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a contiguous BRAM address range and streams the words out in order over valid/ready.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int CW = OCC_W + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic [ADDR_W:0]   remaining_q;
    logic              inflight_q;
    logic              done_q;
    logic [OCC_W-1:0]  occ;
    logic              pop;
    logic              issue;

    assign pop = m_valid & m_ready;

    // Issue only if the word still has a guaranteed buffer slot when it lands next cycle.
    assign issue = (state_q == RUN) && (remaining_q != '0) &&
                   ((CW'(occ) + CW'(inflight_q)) < (CW'(BUF_DEPTH) + CW'(pop)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                addr_cnt_q  <= addr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                remaining_q <= remaining_q - {{ADDR_W{1'b0}}, 1'b1};
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            addr_cnt_q  <= base_addr;
                            remaining_q <= len;
                            state_q     <= RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (remaining_q == {{ADDR_W{1'b0}}, 1'b1})) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Last beat: nothing left in flight and the only buffered word leaves now.
                    if (!inflight_q && (occ == OCC_W'(1)) && pop) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    stream_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (bram_dout),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (m_data)
    );

    assign m_valid   = (occ != '0);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign bram_addr = addr_cnt_q;
    assign bram_we   = 1'b0;
    assign bram_din  = '0;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a RAM model holding mem[i]=i and a beat scoreboard.
module tb_bram_stream_reader;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sb [$];

    int checks   = 0;
    int failures = 0;
    int beat_cnt = 0;
    int done_cnt = 0;

    bram_stream_reader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_we   (bram_we),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model with one cycle of registered read latency.
    always @(posedge clk) begin
        bram_dout <= mem[bram_addr];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one start strobe; the edge that samples it is the one consumed by this task.
    task automatic start_burst(input logic [ADDR_W-1:0] b, input int n, input bit expect_beats);
        start     = 1'b1;
        base_addr = b;
        len       = (ADDR_W+1)'(n);
        if (expect_beats) begin
            for (int i = 0; i < n; i++) begin
                logic [ADDR_W-1:0] a;
                a = b + ADDR_W'(i);
                sb.push_back(DATA_W'(a));
            end
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            step();
            cycles++;
            if (done) break;
        end
        m_ready = 1'b1;
        check("done_within_budget", {31'b0, done}, 32'd1);
    endtask

    // Output monitor: scoreboard compare on each beat, stability under backpressure, done shape.
    logic              hold;
    logic [DATA_W-1:0] held_data;
    logic              prev_done;
    initial begin
        hold      = 1'b0;
        held_data = '0;
        prev_done = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold      = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", {31'b0, m_valid}, 32'd1);
                check("hold_data", 32'(m_data), 32'(held_data));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {31'b0, m_valid}, 32'd0);
                end else begin
                    logic [DATA_W-1:0] exp_d;
                    exp_d = sb.pop_front();
                    check("beat_data", 32'(m_data), 32'(exp_d));
                end
                beat_cnt++;
            end
            if (done) begin
                check("done_single_cycle", {31'b0, prev_done}, 32'd0);
                done_cnt++;
            end
            hold      = m_valid && !m_ready;
            held_data = m_data;
            prev_done = done;
        end
    end

    initial begin
        int cyc;
        int d0;
        int b0;

        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b1;
        #12;
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("bram_we_zero", {31'b0, bram_we}, 32'd0);
        check("bram_din_zero", 32'(bram_din), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic burst with latency checks.
        start_burst(12'h010, 8, 1'b1);
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_addr_k", 32'(bram_addr), 32'h010);
        check("t1_valid_k", {31'b0, m_valid}, 32'd0);
        step();
        check("t1_valid_k1", {31'b0, m_valid}, 32'd0);
        step();
        check("t1_valid_k2", {31'b0, m_valid}, 32'd1);
        check("t1_data_k2", 32'(m_data), 32'h010);
        wait_done(100, 1'b0, cyc);
        check("t1_done_edge", 32'(cyc), 32'd8);
        check("t1_busy_fall", {31'b0, busy}, 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
        step();
        check("t1_done_low", {31'b0, done}, 32'd0);

        // Wrap across the top address.
        start_burst(12'hFFE, 4, 1'b1);
        wait_done(100, 1'b0, cyc);
        check("wrap_done_edge", 32'(cyc), 32'd6);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);
        step();

        // Random backpressure.
        start_burst(12'h123, 16, 1'b1);
        wait_done(400, 1'b1, cyc);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        check("bp_busy", {31'b0, busy}, 32'd0);
        step();

        // Zero-length command.
        d0 = done_cnt;
        b0 = beat_cnt;
        start_burst(12'h055, 0, 1'b0);
        check("len0_done", {31'b0, done}, 32'd1);
        check("len0_busy", {31'b0, busy}, 32'd0);
        check("len0_valid", {31'b0, m_valid}, 32'd0);
        step();
        check("len0_done_low", {31'b0, done}, 32'd0);
        step();
        check("len0_done_count", 32'(done_cnt - d0), 32'd1);
        check("len0_no_beats", 32'(beat_cnt - b0), 32'd0);

        // Start while busy is ignored.
        d0 = done_cnt;
        start_burst(12'h100, 6, 1'b1);
        step();
        step();
        start     = 1'b1;
        base_addr = 12'h200;
        len       = 13'd3;
        step();
        start = 1'b0;
        wait_done(100, 1'b0, cyc);
        check("busy_start_done_edge", 32'(cyc), 32'd5);
        step();
        step();
        step();
        check("busy_start_idle", {31'b0, busy}, 32'd0);
        check("busy_start_done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_start_sb_empty", 32'(sb.size()), 32'd0);

        // Full address range.
        start_burst(12'h000, DEPTH, 1'b1);
        wait_done(DEPTH + 20, 1'b0, cyc);
        check("full_done_edge", 32'(cyc), 32'(DEPTH + 2));
        check("full_sb_empty", 32'(sb.size()), 32'd0);
        step();

        // Reset in the middle of a burst.
        b0 = beat_cnt;
        start_burst(12'h300, 10, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (beat_cnt >= b0 + 3) break;
            step();
        end
        check("mid_rst_three_beats", 32'(beat_cnt - b0), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, m_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_addr", 32'(bram_addr), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        start_burst(12'h400, 5, 1'b1);
        step();
        step();
        check("post_rst_valid", {31'b0, m_valid}, 32'd1);
        check("post_rst_first", 32'(m_data), 32'h400);
        wait_done(100, 1'b0, cyc);
        check("post_rst_done_edge", 32'(cyc), 32'd5);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
